timer_dev: RTL and testbench
============================

# timer_dev

Memory-mapped countdown timer on the CPU's peripheral bus (addresses above 0x7EFF). It is the responder side of the controller's peripheral-access and interrupt path. The CPU writes it with `wecpu` and reads it through the `Mem_to_Reg` peripheral path. The timer drives the `IntReq` line that the controller samples in its WB_cal, WB_dm and BRANCH states. It provides one-shot and auto-reload modes and a maskable, sticky interrupt that software clears.

## Interface
- `BASE_ADDR`, default 32'h0000_7F00: word-aligned base address. The block decodes `addr[31:4] == BASE_ADDR[31:4]`.
- `clk`, input, 1: system clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `addr`, input, 32: CPU byte address. `addr[3:2]` selects the register.
- `we`, input, 1: write strobe. Driven by the controller's `wecpu`.
- `wdata`, input, 32: write data (rt value).
- `rdata`, output, 32: combinational read data for `addr`. Reads 0 when the block is not selected.
- `IntReq`, output, 1: interrupt request, equal to `pend & CTRL.IM`.

## Operation
- **Register map** (offset = `addr[3:2]`):
  - 0 CTRL, read/write.
  - 1 PRESET, read/write.
  - 2 COUNT, read-only. Writes are ignored.
  - 3 reserved. Reads 0, writes are ignored.
- **CTRL bits:**
  - [0] En.
  - [2:1] Mode: 00 one-shot, 01 auto-reload, 1x behaves as 00.
  - [3] IM (interrupt mask, 1 = enabled).
  - [31:4] read 0.
- **Reset values:** CTRL=0, PRESET=0, COUNT=0, state=IDLE, pend=0, `IntReq`=0.
- **FSM states:** IDLE, LOAD, CNT, INT.
- **IDLE:** if En=1, go to LOAD. COUNT holds.
- **LOAD:** COUNT ← PRESET, then go to CNT.
- **CNT:**
  - If En=0, go to IDLE; COUNT holds.
  - Else if COUNT > 1, COUNT ← COUNT−1.
  - Else (COUNT ≤ 1), COUNT ← 0, pend ← 1, go to INT.
- **INT:**
  - Mode 01: go to LOAD.
  - Otherwise: CTRL.En ← 0, go to IDLE.
- **PRESET=0** behaves exactly as PRESET=1.
- **Clearing pend:** pend is sticky. Any CPU write to CTRL clears it.
  - If the pend-set (CNT→INT) and a CTRL write land on the same edge, set wins and pend=1.
- **Simultaneous CPU write and FSM auto-clear of En (INT, one-shot):** the CPU write value wins.
- **PRESET writes** never alter COUNT directly. They take effect at the next LOAD.
- **Read decode:** `rdata` is combinational from the current register values. A read in the same cycle as a write returns the pre-write value.
- **Mode changes:** the FSM uses the registered CTRL. A mode change takes effect the cycle after the write.
- **Reset mid-count:** reset forces every reset value on the next edge, regardless of state or a concurrent `we`.

## Timing
- Enable written on edge t:
  - Edge t+1: state LOAD.
  - Edge t+2: COUNT = PRESET (=N ≥ 1), state CNT.
  - Edge t+2+k: COUNT = N−k.
  - Edge t+2+N: COUNT = 0, state INT, pend = 1. `IntReq` is high from edge t+2+N if IM = 1.
- Auto-reload period is N+2 cycles: INT → LOAD → CNT ×N.
- Clearing En while in CNT stops counting one edge later. The state is IDLE after that edge and COUNT is frozen.
- `IntReq` stays high until a CTRL write, so it is still asserted when the controller reaches its next sampling state (WB_*/BRANCH). It deasserts on the edge of the clearing write.
- `rdata` has zero latency. Write effects are visible one edge after `we`.

## Test plan
1. **Reset state:** assert reset 2 cycles mid-count. Required: all registers read 0, `IntReq`=0, state IDLE.
2. **One-shot with interrupt:**
   - Stimulus: PRESET=5, then CTRL=0x9 (IM, mode 00, En).
   - Required: COUNT reads 5, 4, 3, 2, 1, 0 on successive cycles after LOAD.
   - Required: `IntReq` rises 7 edges after the CTRL write, CTRL reads 0x8, COUNT stays 0.
   - Then write CTRL=0x8. Required: `IntReq` falls on that edge.
3. **Auto-reload:**
   - Stimulus: PRESET=3, CTRL=0xB.
   - Required: COUNT sequence 3, 2, 1, 0, (LOAD) 3, 2, 1, 0…; pend stays set without a CTRL write; period 5 cycles.
4. **Masked interrupt:**
   - Stimulus: PRESET=2, CTRL=0x1.
   - Required: `IntReq` stays 0 after COUNT reaches 0.
   - Then write CTRL=0x8. Required: `IntReq` stays 0 because the write clears pend.
5. **Stop and boundary cases:**
   - CTRL=0x1 with PRESET=10, then CTRL=0 at COUNT=6. Required: COUNT holds at 5 (one more decrement on the write edge), state IDLE.
   - PRESET=0. Required: same timing as PRESET=1.
6. **Decode and collision:**
   - Write to offset 2 and to BASE+0x10. Required: no register changes; `rdata` is 0 for an unselected address.
   - CTRL write on the CNT→INT edge. Required: pend=1.

Source files
------------

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, one-shot or
// auto-reload countdown, and a sticky, maskable interrupt cleared by any CTRL write.
module timer_dev #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        IntReq
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;

  logic        sel, wr_ctrl, wr_preset;
  logic [1:0]  off;
  logic        en, reload, cnt_done;
  logic        unused_addr_lsb;

  assign sel             = (addr[31:4] == BASE_ADDR[31:4]);
  assign off             = addr[3:2];
  assign wr_ctrl         = we && sel && (off == 2'd0);
  assign wr_preset       = we && sel && (off == 2'd1);
  assign unused_addr_lsb = ^addr[1:0];

  assign en       = ctrl_q[0];
  assign reload   = (ctrl_q[2:1] == 2'b01);
  // PRESET=0 falls into the same "<=1" terminal case as PRESET=1
  assign cnt_done = (count_q <= 32'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en) state_d = S_LOAD;
      S_LOAD:  state_d = S_CNT;
      S_CNT:   if (!en) state_d = S_IDLE;
               else if (cnt_done) state_d = S_INT;
      S_INT:   state_d = reload ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;
    case (state_q)
      S_LOAD: count_d = preset_q;
      S_CNT:  if (en) count_d = cnt_done ? 32'd0 : count_q - 32'd1;
      S_INT:  if (!reload) ctrl_d[0] = 1'b0;
      default: ;
    endcase
    // CPU write overrides the one-shot En auto-clear; pend set beats the clear
    if (wr_ctrl) begin
      ctrl_d = wdata[3:0];
      pend_d = 1'b0;
    end
    if (state_q == S_CNT && en && cnt_done) pend_d = 1'b1;
    if (wr_preset) preset_d = wdata;
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (off)
        2'd0:    rdata = {28'd0, ctrl_q};
        2'd1:    rdata = preset_q;
        2'd2:    rdata = count_q;
        default: rdata = '0;
      endcase
    end
  end

  assign IntReq = pend_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev: directed scenarios with literal expectations, then a
// randomized run checked against a spec-level reference model.
module tb_timer_dev;
  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        IntReq;

  int checks = 0;
  int errors = 0;

  timer_dev #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we),
    .wdata(wdata), .rdata(rdata), .IntReq(IntReq)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 loading, 2 counting, 3 fired
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count;
  logic        m_pend;
  int          m_phase;

  task automatic model_step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [3:0]  nc;
    logic [31:0] ncount;
    logic        np, hit;
    int          nph;
    if (r) begin
      m_ctrl = '0; m_preset = '0; m_count = '0; m_pend = 1'b0; m_phase = 0;
      return;
    end
    hit = w && (a[31:4] == BASE[31:4]);
    nc = m_ctrl; ncount = m_count; np = m_pend; nph = m_phase;
    if (m_phase == 0) begin
      if (m_ctrl[0]) nph = 1;
    end else if (m_phase == 1) begin
      ncount = m_preset; nph = 2;
    end else if (m_phase == 2) begin
      if (!m_ctrl[0]) nph = 0;
      else if (m_count > 1) ncount = m_count - 1;
      else begin ncount = 0; nph = 3; end
    end else begin
      if (m_ctrl[2:1] == 2'b01) nph = 1;
      else begin nc[0] = 1'b0; nph = 0; end
    end
    if (hit && a[3:2] == 2'd0) begin nc = d[3:0]; np = 1'b0; end
    if (m_phase == 2 && nph == 3) np = 1'b1;
    if (hit && a[3:2] == 2'd1) m_preset = d;
    m_ctrl = nc; m_count = ncount; m_pend = np; m_phase = nph;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge with the given inputs; returns #1 after the edge
  task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    reset = r; we = w; addr = a; wdata = d;
    model_step(r, w, a, d);
    @(posedge clk);
    #1;
    reset = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    we = 1'b0; addr = a;
    #1;
    v = rdata;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, BASE, 0);
    cyc(1'b1, 1'b0, BASE, 0);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    cyc(0, 1, BASE + 4, 20);
    cyc(0, 1, BASE, 32'h9);
    repeat (5) cyc(0, 0, BASE, 0);
    cyc(1, 1, BASE, 32'hF);
    cyc(1, 1, BASE + 4, 32'h33);
    for (int i = 0; i < 3; i++) begin
      rd(BASE + i * 4, v); checks++;
      if (v !== 32'd0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=0", i, v); end
    end
    checks++;
    if (IntReq !== 1'b0) begin errors++; $display("FAIL reset_intreq got=%b exp=0", IntReq); end
    repeat (3) cyc(0, 0, BASE, 0);
    rd(BASE + 8, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reset_idle_count got=%0d exp=0", v); end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    do_reset();
    cyc(0, 1, BASE + 4, 5);
    cyc(0, 1, BASE, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      cyc(0, 0, BASE, 0);
      rd(BASE + 8, v);
      if (k >= 2) begin
        checks++;
        if (v !== 32'(7 - k)) begin errors++; $display("FAIL oneshot_count k=%0d got=%0d exp=%0d", k, v, 7 - k); end
      end
      checks++;
      if (IntReq !== (k == 7)) begin errors++; $display("FAIL oneshot_intreq k=%0d got=%b exp=%b", k, IntReq, k == 7); end
    end
    repeat (3) cyc(0, 0, BASE, 0);
    rd(BASE, v); checks++;
    if (v !== 32'h8) begin errors++; $display("FAIL oneshot_ctrl got=%h exp=8", v); end
    rd(BASE + 8, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL oneshot_count_hold got=%0d exp=0", v); end
    checks++;
    if (IntReq !== 1'b1) begin errors++; $display("FAIL oneshot_sticky got=%b exp=1", IntReq); end
    cyc(0, 1, BASE, 32'h8);
    checks++;
    if (IntReq !== 1'b0) begin errors++; $display("FAIL oneshot_clear got=%b exp=0", IntReq); end
  endtask

  task automatic test_autoreload();
    logic [31:0] v, e;
    int j;
    do_reset();
    cyc(0, 1, BASE + 4, 3);
    cyc(0, 1, BASE, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 0, BASE, 0);
      rd(BASE + 8, v);
      if (k >= 2) begin
        j = (k - 2) % 5;
        e = (j <= 3) ? 32'(3 - j) : 32'd0;
        checks++;
        if (v !== e) begin errors++; $display("FAIL reload_count k=%0d got=%0d exp=%0d", k, v, e); end
      end
      checks++;
      if (IntReq !== (k >= 5)) begin errors++; $display("FAIL reload_intreq k=%0d got=%b exp=%b", k, IntReq, k >= 5); end
    end
    rd(BASE, v); checks++;
    if (v !== 32'hB) begin errors++; $display("FAIL reload_ctrl got=%h exp=b", v); end
  endtask

  task automatic test_masked();
    logic [31:0] v;
    do_reset();
    cyc(0, 1, BASE + 4, 2);
    cyc(0, 1, BASE, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      cyc(0, 0, BASE, 0);
      checks++;
      if (IntReq !== 1'b0) begin errors++; $display("FAIL masked_intreq k=%0d got=%b exp=0", k, IntReq); end
    end
    rd(BASE + 8, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL masked_count got=%0d exp=0", v); end
    rd(BASE, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL masked_ctrl got=%h exp=0", v); end
    cyc(0, 1, BASE, 32'h8);
    cyc(0, 0, BASE, 0);
    checks++;
    if (IntReq !== 1'b0) begin errors++; $display("FAIL masked_unmask got=%b exp=0", IntReq); end
  endtask

  task automatic test_stop_boundary();
    logic [31:0] v;
    int rise0, rise1;
    do_reset();
    cyc(0, 1, BASE + 4, 10);
    cyc(0, 1, BASE, 32'h1);
    repeat (6) cyc(0, 0, BASE, 0);
    rd(BASE + 8, v); checks++;
    if (v !== 32'd6) begin errors++; $display("FAIL stop_pre got=%0d exp=6", v); end
    cyc(0, 1, BASE, 32'h0);
    rd(BASE + 8, v); checks++;
    if (v !== 32'd5) begin errors++; $display("FAIL stop_edge got=%0d exp=5", v); end
    repeat (4) cyc(0, 0, BASE, 0);
    rd(BASE + 8, v); checks++;
    if (v !== 32'd5) begin errors++; $display("FAIL stop_hold got=%0d exp=5", v); end
    for (int p = 0; p < 2; p++) begin
      int rise;
      rise = -1;
      do_reset();
      cyc(0, 1, BASE + 4, 32'(p));
      cyc(0, 1, BASE, 32'h9);
      for (int k = 1; k <= 6; k++) begin
        cyc(0, 0, BASE, 0);
        if (IntReq === 1'b1 && rise < 0) rise = k;
      end
      if (p == 0) rise0 = rise; else rise1 = rise;
    end
    checks++;
    if (rise1 !== 3) begin errors++; $display("FAIL preset1_rise got=%0d exp=3", rise1); end
    checks++;
    if (rise0 !== rise1) begin errors++; $display("FAIL preset0_rise got=%0d exp=%0d", rise0, rise1); end
  endtask

  task automatic test_decode_collision();
    logic [31:0] v;
    do_reset();
    cyc(0, 1, BASE + 4, 7);
    cyc(0, 1, BASE + 8, 32'h55);
    cyc(0, 1, BASE + 12, 32'h66);
    cyc(0, 1, BASE + 32'h10, 32'hF);
    cyc(0, 1, BASE + 32'h14, 32'h99);
    rd(BASE, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL decode_ctrl got=%h exp=0", v); end
    rd(BASE + 4, v); checks++;
    if (v !== 32'd7) begin errors++; $display("FAIL decode_preset got=%h exp=7", v); end
    rd(BASE + 8, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL decode_count got=%h exp=0", v); end
    rd(BASE + 12, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL decode_rsvd got=%h exp=0", v); end
    rd(BASE + 32'h14, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL decode_unsel got=%h exp=0", v); end
    addr = BASE + 4; we = 1'b1; wdata = 32'h77; #1;
    checks++;
    if (rdata !== 32'd7) begin errors++; $display("FAIL read_prewrite got=%h exp=7", rdata); end
    we = 1'b0;
    // Collision: CTRL write on the CNT->INT edge, then on the auto-clear edge
    do_reset();
    cyc(0, 1, BASE + 4, 2);
    cyc(0, 1, BASE, 32'h9);
    repeat (3) cyc(0, 0, BASE, 0);
    cyc(0, 1, BASE, 32'h9);
    checks++;
    if (IntReq !== 1'b1) begin errors++; $display("FAIL collide_set got=%b exp=1", IntReq); end
    cyc(0, 1, BASE, 32'h9);
    rd(BASE, v); checks++;
    if (v !== 32'h9) begin errors++; $display("FAIL collide_ctrl got=%h exp=9", v); end
    checks++;
    if (IntReq !== 1'b0) begin errors++; $display("FAIL collide_clear got=%b exp=0", IntReq); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, v;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic r, w;
      r = ($urandom_range(0, 99) == 0);
      w = ($urandom_range(0, 99) < 30);
      a = BASE + 32'($urandom_range(0, 3) * 4);
      if ($urandom_range(0, 9) == 0) a = a + 32'h10;
      d = (a[3:2] == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
      cyc(r, w, a, d);
      for (int i = 0; i < 3; i++) begin
        rd(BASE + i * 4, v); checks++;
        if (v !== m_read(BASE + i * 4)) begin
          errors++; $display("FAIL rand_reg%0d n=%0d got=%h exp=%h", i, n, v, m_read(BASE + i * 4));
        end
      end
      checks++;
      if (IntReq !== (m_pend & m_ctrl[3])) begin
        errors++; $display("FAIL rand_intreq n=%0d got=%b exp=%b", n, IntReq, m_pend & m_ctrl[3]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_step(1'b1, 1'b0, BASE, 0);
    #1;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_masked();
    test_stop_boundary();
    test_decode_collision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
